// File: rtl/cram_diag_ctl.sv
// Front-end diagnostic controller for the 2K-word CRAM array.
// Builds 84-bit microwords from three 28-bit chunks, writes them to CRAM,
// reads CRAM words back, and muxes the CRAM address between the
// microsequencer (CRADR) and diagnostic access while the CPU is halted.
// Bit numbering of the microword: CRAM bit 0 is the MSB (cram_wdata[83]).
module cram_diag_ctl #(
  parameter int ADDR_MAX     = 2047,
  parameter int READ_LAT     = 1,
  parameter int HALT_TIMEOUT = 255,
  parameter int AUTOINC      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_run,
  input  logic [11:0] CRADR,
  input  logic        diag_addr_ld,
  input  logic        diag_wr,
  input  logic [1:0]  diag_sel,
  input  logic [27:0] diag_data,
  input  logic        diag_commit,
  input  logic        diag_rd,
  input  logic [83:0] cram_rdata,
  output logic [27:0] diag_rdata,
  output logic [11:0] diag_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] cram_addr,
  output logic        cram_we,
  output logic [83:0] cram_wdata
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HALT = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_WAIT = 3'd3,
    S_CAPTURE   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [11:0] ADDR_MAX_L = 12'(ADDR_MAX);
  localparam logic [15:0] TMO_L      = 16'(HALT_TIMEOUT);
  localparam logic [15:0] LAT_LAST_L = 16'(READ_LAT - 1);
  localparam logic        AUTOINC_L  = (AUTOINC != 0);

  state_t      state_q, state_d;
  logic [83:0] stage_q, stage_d;
  logic [83:0] rdbk_q, rdbk_d;
  logic [11:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pend_rd_q, pend_rd_d;
  logic        ok_q, ok_d;

  logic        idle;
  logic        any_cmd;
  logic        cmd_conflict;
  logic        cmd_start;
  logic        addr_bad;
  logic        timeout_hit;
  logic [15:0] cnt_inc;

  assign idle         = (state_q == S_IDLE);
  assign any_cmd      = diag_wr | diag_addr_ld | diag_commit | diag_rd;
  assign cmd_conflict = diag_commit & diag_rd;
  assign cmd_start    = idle & (diag_commit ^ diag_rd);
  assign addr_bad     = (diag_data[11:0] > ADDR_MAX_L);
  assign cnt_inc      = cnt_q + 16'd1;
  // A pending command that sees cpu_run=0 proceeds even on the last wait cycle.
  assign timeout_hit  = (state_q == S_WAIT_HALT) & cpu_run & (cnt_inc >= TMO_L);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          if (cpu_run)      state_d = S_WAIT_HALT;
          else if (diag_rd) state_d = S_READ_WAIT;
          else              state_d = S_WRITE;
        end
      end
      S_WAIT_HALT: begin
        if (!cpu_run)         state_d = pend_rd_q ? S_READ_WAIT : S_WRITE;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_WRITE:     state_d = S_DONE;
      S_READ_WAIT: if (cnt_q >= LAT_LAST_L) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    cram_we    = (state_q == S_WRITE);
    cram_addr  = CRADR;
    if ((state_q == S_WRITE) || (state_q == S_READ_WAIT) || (state_q == S_CAPTURE)) begin
      cram_addr = addr_q;
    end
    cram_wdata = stage_q;
    diag_addr  = addr_q;
    err        = err_q;
    case (diag_sel)
      2'd0:    diag_rdata = rdbk_q[83:56];
      2'd1:    diag_rdata = rdbk_q[55:28];
      2'd2:    diag_rdata = rdbk_q[27:0];
      default: diag_rdata = 28'd0;
    endcase
  end

  // Datapath next-state: staging, readback, address, error, counters
  always_comb begin
    stage_d   = stage_q;
    rdbk_d    = rdbk_q;
    addr_d    = addr_q;
    err_d     = err_q;
    pend_rd_d = pend_rd_q;
    ok_d      = ok_q;
    cnt_d     = 16'd0;

    // The counter runs only while dwelling in a waiting state.
    if ((state_d == state_q) &&
        ((state_q == S_WAIT_HALT) || (state_q == S_READ_WAIT))) begin
      cnt_d = cnt_inc;
    end

    if (idle) begin
      if (diag_wr) begin
        case (diag_sel)
          2'd0:    stage_d[83:56] = diag_data;
          2'd1:    stage_d[55:28] = diag_data;
          2'd2:    stage_d[27:0]  = diag_data;
          default: stage_d        = stage_q;
        endcase
      end
      if (diag_addr_ld && !addr_bad) begin
        addr_d = diag_data[11:0];
        err_d  = 1'b0;
      end
      if (cmd_start) begin
        pend_rd_d = diag_rd;
        ok_d      = 1'b1;
      end
      // Error sources take priority over the clear from a legal address load.
      if ((diag_wr && (diag_sel == 2'd3)) || (diag_addr_ld && addr_bad) || cmd_conflict) begin
        err_d = 1'b1;
      end
    end else begin
      if (any_cmd) err_d = 1'b1;
    end

    if (timeout_hit) begin
      err_d = 1'b1;
      ok_d  = 1'b0;
    end

    if (state_q == S_CAPTURE) begin
      rdbk_d = cram_rdata;
    end

    if ((state_q == S_DONE) && ok_q && AUTOINC_L) begin
      addr_d = (addr_q >= ADDR_MAX_L) ? 12'd0 : addr_q + 12'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q   <= '0;
      rdbk_q    <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      pend_rd_q <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      rdbk_q    <= rdbk_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      ok_q      <= ok_d;
    end
  end

endmodule
